// File: rtl/wb_mc_pkg.sv
// Shared types and constant helpers for the multi-channel white-balance corrector.
package wb_mc_pkg;

    localparam int unsigned WB_PX_WIDTH    = 10;
    localparam int unsigned WB_CHANNELS    = 3;
    localparam int unsigned WB_FRACT_WIDTH = 10;
    localparam int unsigned WB_GAIN_WIDTH  = 14;

    typedef logic [WB_GAIN_WIDTH-1:0] gain_t;

    // Gain value representing 1.0 for a given number of fractional bits.
    function automatic logic [31:0] unity_gain(input int unsigned fract_w);
        return 32'd1 << fract_w;
    endfunction

    // Half-LSB offset added before truncation to get round-half-up.
    function automatic logic [31:0] round_const(input int unsigned fract_w);
        return (fract_w == 0) ? 32'd0 : (32'd1 << (fract_w - 1));
    endfunction

endpackage

// File: rtl/wb_mc_channel.sv
// One colour component: multiply by gain, then round, saturate or bypass.
module wb_mc_channel
    import wb_mc_pkg::*;
#(
    parameter int unsigned PX_WIDTH    = WB_PX_WIDTH,
    parameter int unsigned FRACT_WIDTH = WB_FRACT_WIDTH,
    parameter int unsigned GAIN_WIDTH  = WB_GAIN_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  bypass_i,
    input  logic [GAIN_WIDTH-1:0] gain_i,
    input  logic [PX_WIDTH-1:0]   px_i,
    output logic [PX_WIDTH-1:0]   px_o
);

    localparam int unsigned PROD_W = PX_WIDTH + GAIN_WIDTH;
    localparam int unsigned SUM_W  = PROD_W + 1;
    localparam int unsigned RES_W  = SUM_W - FRACT_WIDTH;
    localparam logic [SUM_W-1:0]    RND    = SUM_W'(round_const(FRACT_WIDTH));
    localparam logic [PX_WIDTH-1:0] PX_MAX = '1;

    logic [PROD_W-1:0]   r_prod;
    logic [PX_WIDTH-1:0] r_px;
    logic                r_bypass;
    logic [PX_WIDTH-1:0] r_out;
    logic [RES_W-1:0]    w_res;
    logic [PX_WIDTH-1:0] w_sat;

    // Stage 1: full-precision product, raw pixel kept for bypass.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prod   <= '0;
            r_px     <= '0;
            r_bypass <= 1'b0;
        end else if (en_i) begin
            r_prod   <= PROD_W'(px_i) * PROD_W'(gain_i);
            r_px     <= px_i;
            r_bypass <= bypass_i;
        end
    end

    always_comb begin
        w_res = RES_W'((SUM_W'(r_prod) + RND) >> FRACT_WIDTH);
        w_sat = (w_res > RES_W'(PX_MAX)) ? PX_MAX : w_res[PX_WIDTH-1:0];
    end

    // Stage 2: rounded and clipped result, or the untouched pixel.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out <= '0;
        end else if (en_i) begin
            r_out <= r_bypass ? r_px : w_sat;
        end
    end

    assign px_o = r_out;

endmodule

// File: rtl/wb_corrector_mc.sv
// Multi-channel white-balance stage: frame-synchronous gain/bypass update,
// two-stage channel pipeline and matching sideband delay line.
module wb_corrector_mc
    import wb_mc_pkg::*;
#(
    parameter int unsigned PX_WIDTH      = WB_PX_WIDTH,
    parameter int unsigned CHANNELS      = WB_CHANNELS,
    parameter int unsigned TDATA_WIDTH   = 32,
    parameter int unsigned TDATA_WIDTH_B = TDATA_WIDTH / 8,
    parameter int unsigned FRACT_WIDTH   = WB_FRACT_WIDTH,
    parameter int unsigned GAIN_WIDTH    = WB_GAIN_WIDTH
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           video_i_tvalid,
    output logic                           video_i_tready,
    input  logic [TDATA_WIDTH-1:0]         video_i_tdata,
    input  logic [TDATA_WIDTH_B-1:0]       video_i_tstrb,
    input  logic [TDATA_WIDTH_B-1:0]       video_i_tkeep,
    input  logic                           video_i_tlast,
    input  logic                           video_i_tuser,
    input  logic                           video_i_tid,
    input  logic                           video_i_tdest,
    output logic                           video_o_tvalid,
    input  logic                           video_o_tready,
    output logic [TDATA_WIDTH-1:0]         video_o_tdata,
    output logic [TDATA_WIDTH_B-1:0]       video_o_tstrb,
    output logic [TDATA_WIDTH_B-1:0]       video_o_tkeep,
    output logic                           video_o_tlast,
    output logic                           video_o_tuser,
    output logic                           video_o_tid,
    output logic                           video_o_tdest,
    input  logic [CHANNELS*GAIN_WIDTH-1:0] gain_i,
    input  logic                           bypass_i,
    input  logic                           gain_upd_i,
    output logic                           gain_applied_o,
    output logic                           upd_pending_o
);

    localparam int unsigned SB_W = 2 * TDATA_WIDTH_B + 4;
    localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(unity_gain(FRACT_WIDTH));

    logic                  w_en;
    logic                  w_hs;
    logic                  w_load;
    logic                  w_byp_cur;
    logic                  w_unused_tdata;
    logic [GAIN_WIDTH-1:0] w_gain_cur [CHANNELS];
    logic [GAIN_WIDTH-1:0] r_shadow   [CHANNELS];
    logic [GAIN_WIDTH-1:0] r_active   [CHANNELS];
    logic                  r_byp_shadow;
    logic                  r_byp_active;
    logic                  r_pending;
    logic                  r_applied;
    logic                  r_v1;
    logic                  r_v2;
    logic [SB_W-1:0]       w_sb_in;
    logic [SB_W-1:0]       r_sb1;
    logic [SB_W-1:0]       r_sb2;
    logic [PX_WIDTH-1:0]   w_ch_px [CHANNELS];
    logic [TDATA_WIDTH-1:0] w_tdata;

    assign w_en           = !r_v2 || video_o_tready;
    assign w_hs           = video_i_tvalid && w_en;
    assign w_load         = w_hs && video_i_tuser && r_pending;
    assign video_i_tready = w_en;
    assign w_unused_tdata = ^video_i_tdata;

    // The SOF beat that triggers a load already sees the shadow values.
    always_comb begin
        w_byp_cur = w_load ? r_byp_shadow : r_byp_active;
        for (int c = 0; c < CHANNELS; c++) begin
            w_gain_cur[c] = w_load ? r_shadow[c] : r_active[c];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_shadow[c] <= UNITY;
                r_active[c] <= UNITY;
            end
            r_byp_shadow <= 1'b0;
            r_byp_active <= 1'b0;
            r_pending    <= 1'b0;
            r_applied    <= 1'b0;
        end else begin
            if (gain_upd_i) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    r_shadow[c] <= gain_i[c*GAIN_WIDTH +: GAIN_WIDTH];
                end
                r_byp_shadow <= bypass_i;
            end
            if (w_load) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    r_active[c] <= r_shadow[c];
                end
                r_byp_active <= r_byp_shadow;
            end
            // A strobe coinciding with a load stays pending for the next SOF.
            r_pending <= gain_upd_i || (r_pending && !w_load);
            r_applied <= w_load;
        end
    end

    assign w_sb_in = {video_i_tstrb, video_i_tkeep, video_i_tlast,
                      video_i_tuser, video_i_tid, video_i_tdest};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_sb1 <= '0;
            r_sb2 <= '0;
        end else if (w_en) begin
            r_v1  <= video_i_tvalid;
            r_v2  <= r_v1;
            r_sb1 <= w_sb_in;
            r_sb2 <= r_sb1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        wb_mc_channel #(
            .PX_WIDTH   (PX_WIDTH),
            .FRACT_WIDTH(FRACT_WIDTH),
            .GAIN_WIDTH (GAIN_WIDTH)
        ) u_ch (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (w_en),
            .bypass_i(w_byp_cur),
            .gain_i  (w_gain_cur[c]),
            .px_i    (video_i_tdata[c*PX_WIDTH +: PX_WIDTH]),
            .px_o    (w_ch_px[c])
        );
    end

    always_comb begin
        w_tdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_tdata[c*PX_WIDTH +: PX_WIDTH] = w_ch_px[c];
        end
    end

    assign video_o_tvalid = r_v2;
    assign video_o_tdata  = w_tdata;
    assign {video_o_tstrb, video_o_tkeep, video_o_tlast,
            video_o_tuser, video_o_tid, video_o_tdest} = r_sb2;
    assign gain_applied_o = r_applied;
    assign upd_pending_o  = r_pending;

endmodule

// File: tb/tb_wb_corrector_mc.sv
// Directed bench for wb_corrector_mc with a beat scoreboard on the output stream.
`timescale 1ns/1ps
module tb_wb_corrector_mc;
    import wb_mc_pkg::*;

    localparam int unsigned PW = 10;
    localparam int unsigned CH = 3;
    localparam int unsigned TW = 32;
    localparam int unsigned TB = 4;
    localparam int unsigned FW = 10;
    localparam int unsigned GW = 14;

    typedef struct packed {
        logic [31:0] data;
        logic [11:0] sb;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic video_i_tvalid = 1'b0;
    logic video_i_tready;
    logic [TW-1:0] video_i_tdata = '0;
    logic [TB-1:0] video_i_tstrb = '0;
    logic [TB-1:0] video_i_tkeep = '0;
    logic video_i_tlast = 1'b0, video_i_tuser = 1'b0, video_i_tid = 1'b0, video_i_tdest = 1'b0;
    logic video_o_tvalid;
    logic video_o_tready = 1'b1;
    logic [TW-1:0] video_o_tdata;
    logic [TB-1:0] video_o_tstrb, video_o_tkeep;
    logic video_o_tlast, video_o_tuser, video_o_tid, video_o_tdest;
    logic [CH*GW-1:0] gain_i = {CH{14'h400}};
    logic bypass_i = 1'b0, gain_upd_i = 1'b0;
    logic gain_applied_o, upd_pending_o;

    int unsigned n_total = 0;
    int unsigned n_bad = 0;
    int unsigned cyc_n = 0;
    int unsigned n_appl = 0;
    int unsigned n_rx = 0;
    logic rand_rdy = 1'b0;
    logic chk_lat = 1'b1;

    exp_t        q_exp[$];
    logic [31:0] q_got[$];
    gain_t       m_act[CH];
    gain_t       m_sh[CH];
    logic        m_byp_a, m_byp_s, m_pend, m_appl;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = '0;

    wb_corrector_mc dut (
        .clk_i(clk), .rst_i(rst_i),
        .video_i_tvalid(video_i_tvalid), .video_i_tready(video_i_tready),
        .video_i_tdata(video_i_tdata), .video_i_tstrb(video_i_tstrb),
        .video_i_tkeep(video_i_tkeep), .video_i_tlast(video_i_tlast),
        .video_i_tuser(video_i_tuser), .video_i_tid(video_i_tid),
        .video_i_tdest(video_i_tdest),
        .video_o_tvalid(video_o_tvalid), .video_o_tready(video_o_tready),
        .video_o_tdata(video_o_tdata), .video_o_tstrb(video_o_tstrb),
        .video_o_tkeep(video_o_tkeep), .video_o_tlast(video_o_tlast),
        .video_o_tuser(video_o_tuser), .video_o_tid(video_o_tid),
        .video_o_tdest(video_o_tdest),
        .gain_i(gain_i), .bypass_i(bypass_i), .gain_upd_i(gain_upd_i),
        .gain_applied_o(gain_applied_o), .upd_pending_o(upd_pending_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        return {2'b00, c, b, a};
    endfunction

    function automatic logic [9:0] ref_px(input logic [9:0] px, input gain_t g);
        int unsigned p;
        p = (32'(px) * 32'(g) + 32'd512) >> 10;
        return (p > 32'd1023) ? 10'h3FF : 10'(p);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_act[c] = 14'h400;
            m_sh[c]  = 14'h400;
        end
        m_byp_a = 1'b0; m_byp_s = 1'b0; m_pend = 1'b0; m_appl = 1'b0;
        stall_prev = 1'b0;
        q_exp.delete();
    endtask

    // Observes both handshakes once per cycle, away from the rising edge.
    task automatic sample();
        exp_t        e;
        logic        ld;
        logic [9:0]  px;
        cyc_n++;
        if (rst_i) begin
            model_reset();
            return;
        end
        check("upd_pending", 32'(upd_pending_o), 32'(m_pend));
        check("gain_applied", 32'(gain_applied_o), 32'(m_appl));
        if (gain_applied_o) n_appl++;
        if (stall_prev) begin
            check("stall_valid", 32'(video_o_tvalid), 32'd1);
            check("stall_data", video_o_tdata, stall_data);
        end
        stall_prev = video_o_tvalid && !video_o_tready;
        stall_data = video_o_tdata;
        if (video_o_tvalid && video_o_tready) begin
            n_rx++;
            q_got.push_back(video_o_tdata);
            if (q_exp.size() == 0) begin
                check("spurious_beat", 32'd1, 32'd0);
            end else begin
                e = q_exp.pop_front();
                check("tdata", video_o_tdata, e.data);
                check("sideband", 32'({video_o_tstrb, video_o_tkeep, video_o_tlast,
                                       video_o_tuser, video_o_tid, video_o_tdest}), 32'(e.sb));
                if (chk_lat) check("latency", cyc_n, e.cyc);
            end
        end
        ld = 1'b0;
        if (video_i_tvalid && video_i_tready) begin
            ld = video_i_tuser && m_pend;
            if (ld) begin
                m_act = m_sh;
                m_byp_a = m_byp_s;
            end
            e.data = '0;
            for (int c = 0; c < CH; c++) begin
                px = video_i_tdata[c*PW +: PW];
                e.data[c*PW +: PW] = m_byp_a ? px : ref_px(px, m_act[c]);
            end
            e.sb  = {video_i_tstrb, video_i_tkeep, video_i_tlast, video_i_tuser, video_i_tid, video_i_tdest};
            e.cyc = cyc_n + 2;
            q_exp.push_back(e);
        end
        m_appl = ld;
        if (gain_upd_i) begin
            for (int c = 0; c < CH; c++) m_sh[c] = gain_i[c*GW +: GW];
            m_byp_s = bypass_i;
            m_pend  = 1'b1;
        end else if (ld) begin
            m_pend = 1'b0;
        end
    endtask

    always @(negedge clk) sample();

    task automatic tick();
        @(posedge clk);
        #1;
        video_o_tready = rand_rdy ? ($urandom_range(0, 99) >= 30) : 1'b1;
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic sof, input logic eol, input logic upd);
        logic acc;
        int unsigned n;
        video_i_tvalid = 1'b1;
        video_i_tdata  = d;
        video_i_tuser  = sof;
        video_i_tlast  = eol;
        video_i_tstrb  = 4'($urandom);
        video_i_tkeep  = 4'($urandom);
        video_i_tid    = 1'($urandom);
        video_i_tdest  = 1'($urandom);
        gain_upd_i     = upd;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 1000) begin
            acc = video_i_tready;
            tick();
            gain_upd_i = 1'b0;
            n++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic strobe(input gain_t g0, input gain_t g1, input gain_t g2, input logic byp);
        video_i_tvalid = 1'b0;
        gain_i   = {g2, g1, g0};
        bypass_i = byp;
        gain_upd_i = 1'b1;
        tick();
        gain_upd_i = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        video_i_tvalid = 1'b0;
        n = 0;
        while ((q_exp.size() != 0 || video_o_tvalid) && n < 2000) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(q_exp.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] in_d[8];
        int unsigned rx0;

        // Reset state
        repeat (3) tick();
        check("rst_tvalid", 32'(video_o_tvalid), 32'd0);
        check("rst_tdata", video_o_tdata, 32'd0);
        check("rst_pending", 32'(upd_pending_o), 32'd0);
        check("rst_applied", 32'(gain_applied_o), 32'd0);
        check("rst_tready", 32'(video_i_tready), 32'd1);
        rst_i = 1'b0;
        tick();

        // Unity gains: output equals input (MSBs cleared), back-to-back beats
        q_got.delete();
        for (int i = 0; i < 8; i++) begin
            in_d[i] = $urandom;
            send(in_d[i], i == 0, i == 7, 1'b0);
        end
        drain();
        check("unity_count", 32'(q_got.size()), 32'd8);
        for (int i = 0; i < 8 && i < q_got.size(); i++)
            check("unity_data", q_got[i], in_d[i] & 32'h3FFF_FFFF);

        // Gain 1.5 / rounding boundary / saturation
        strobe(14'h600, 14'h401, 14'h400, 1'b0);
        check("pend_set", 32'(upd_pending_o), 32'd1);
        q_got.delete();
        send(mk(10'h200, 10'h001, 10'h155), 1'b1, 1'b0, 1'b0);
        send(mk(10'h300, 10'h3FF, 10'h000), 1'b0, 1'b0, 1'b0);
        send(mk(10'h002, 10'h001, 10'h3FF), 1'b0, 1'b1, 1'b0);
        drain();
        check("gain_1p5", q_got[0], 32'h1550_0700);
        check("gain_sat", q_got[1], 32'h000F_FFFF);
        check("gain_rnd", q_got[2], 32'h3FF0_0403);
        check("appl_cnt1", n_appl, 32'd1);
        check("pend_clr1", 32'(upd_pending_o), 32'd0);

        // Mid-frame update waits for the next SOF
        q_got.delete();
        send(mk(10'h010, 10'h010, 10'h010), 1'b1, 1'b0, 1'b0);
        strobe(14'h800, 14'h800, 14'h800, 1'b0);
        send(mk(10'h010, 10'h010, 10'h010), 1'b0, 1'b1, 1'b0);
        check("pend_mid", 32'(upd_pending_o), 32'd1);
        send(mk(10'h010, 10'h010, 10'h010), 1'b1, 1'b0, 1'b0);
        drain();
        check("mid_old0", q_got[0], 32'h0100_4018);
        check("mid_old1", q_got[1], 32'h0100_4018);
        check("mid_new", q_got[2], 32'h0200_8020);
        check("appl_cnt2", n_appl, 32'd2);
        check("pend_clr2", 32'(upd_pending_o), 32'd0);

        // Strobe on the SOF handshake itself applies at the following SOF
        q_got.delete();
        gain_i = {CH{14'hC00}};
        send(mk(10'h010, 10'h010, 10'h010), 1'b1, 1'b0, 1'b1);
        send(mk(10'h010, 10'h010, 10'h010), 1'b0, 1'b1, 1'b0);
        check("pend_sof", 32'(upd_pending_o), 32'd1);
        check("appl_cnt3a", n_appl, 32'd2);
        send(mk(10'h010, 10'h010, 10'h010), 1'b1, 1'b0, 1'b0);
        drain();
        check("sof_old0", q_got[0], 32'h0200_8020);
        check("sof_old1", q_got[1], 32'h0200_8020);
        check("sof_new", q_got[2], 32'h0300_C030);
        check("appl_cnt3", n_appl, 32'd3);

        // Bypass passes components untouched
        q_got.delete();
        strobe(14'h800, 14'h800, 14'h800, 1'b1);
        send(mk(10'h100, 10'h3FF, 10'h001), 1'b1, 1'b0, 1'b0);
        drain();
        check("bypass", q_got[0], 32'h001F_FD00);

        // Reset mid-frame with a pending bypass update
        q_got.delete();
        strobe(14'h800, 14'h800, 14'h800, 1'b0);
        send(mk(10'h100, 10'h100, 10'h100), 1'b1, 1'b0, 1'b0);
        drain();
        check("gain_2x", q_got[0], 32'h2008_0200);
        strobe(14'h800, 14'h800, 14'h800, 1'b1);
        send(mk(10'h050, 10'h050, 10'h050), 1'b0, 1'b0, 1'b0);
        send(mk(10'h060, 10'h060, 10'h060), 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
        video_i_tvalid = 1'b0;
        tick();
        check("mrst_tvalid", 32'(video_o_tvalid), 32'd0);
        check("mrst_tdata", video_o_tdata, 32'd0);
        check("mrst_tuser", 32'(video_o_tuser), 32'd0);
        check("mrst_pending", 32'(upd_pending_o), 32'd0);
        rst_i = 1'b0;
        tick();
        q_got.delete();
        send(mk(10'h123, 10'h123, 10'h123), 1'b1, 1'b1, 1'b0);
        drain();
        check("post_rst_unity", q_got[0], 32'h1234_8D23);
        check("post_rst_pend", 32'(upd_pending_o), 32'd0);

        // Three 16x4 frames with 30% downstream stalls
        chk_lat  = 1'b0;
        rand_rdy = 1'b1;
        rx0 = n_rx;
        strobe(14'h500, 14'h3C0, 14'h6A0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 16; c++) begin
                    if (f == 1 && r == 2 && c == 0) strobe(14'h280, 14'h7FF, 14'h400, 1'b0);
                    send($urandom, (r == 0 && c == 0), (c == 15), 1'b0);
                end
            end
        end
        drain();
        check("stall_beats", n_rx - rx0, 32'd192);
        rand_rdy = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
